mod_acc_2011: RTL and testbench

Sequential modulo-2011 accumulator that consumes the 11-bit partial residues produced by the per-chunk 6-bit LUT stages of the 500-bit reducer. Partial residues arrive one per cycle over a valid/ready stream and are summed mod 2011. One frame covers up to 84 chunks, since 500 bits is 84 six-bit chunks. The block emits the final residue of the 500-bit operand on a registered valid/ready output.

---
 rtl/mod_acc_2011.sv | 101 ++++++++++
 tb/tb_mod_acc_2011.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mod_acc_2011.sv
// Streaming modulo-MOD accumulator: sums one partial residue per beat, emits frame residue.
// Optional input range reduction and error flag enabled by defining MOD_ACC_RANGE_CHECK_EN.
module mod_acc_2011 #(
  parameter int MOD    = 2011,
  parameter int W      = 11,
  parameter int NCHUNK = 84,
  parameter int CW     = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [W-1:0]  s_data,
  input  logic          s_last,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [W-1:0]  m_data,
  output logic [CW-1:0] m_beats,
  output logic          m_err
);

  // state | meaning
  // IDLE  | no frame in progress, accumulator treated as zero
  // ACC   | frame open, at least one beat summed
  // DONE  | result held on m_*, input stalled until output handshake
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  acc, acc_base, acc_next, d;
  logic [W:0]    sum;
  logic [CW-1:0] cnt, cnt_base;
  logic          beat, closing;

  assign s_ready  = (state != DONE);
  assign m_valid  = (state == DONE);
  assign beat     = s_valid & s_ready;
  assign acc_base = (state == IDLE) ? '0 : acc;
  assign cnt_base = (state == IDLE) ? '0 : cnt;
  assign closing  = s_last | (cnt_base == CW'(NCHUNK - 1));

`ifdef MOD_ACC_RANGE_CHECK_EN
  logic in_bad, err_flag;
  // A single subtraction suffices because 2*MOD exceeds the input range.
  assign in_bad = (s_data >= W'(MOD));
  assign d      = in_bad ? s_data - W'(MOD) : s_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_flag <= 1'b0;
      m_err    <= 1'b0;
    end else if (state == DONE) begin
      if (m_ready) err_flag <= 1'b0;
    end else if (beat) begin
      err_flag <= err_flag | in_bad;
      if (closing) m_err <= err_flag | in_bad;
    end
  end
`else
  assign d     = s_data;
  assign m_err = 1'b0;
`endif

  assign sum      = {1'b0, acc_base} + {1'b0, d};
  assign acc_next = (sum >= (W+1)'(MOD)) ? W'(sum - (W+1)'(MOD)) : W'(sum);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, ACC: if (beat) state_nxt = closing ? DONE : ACC;
      DONE:      if (m_ready) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      cnt     <= '0;
      m_data  <= '0;
      m_beats <= '0;
    end else if (state == DONE) begin
      if (m_ready) begin
        acc <= '0;
        cnt <= '0;
      end
    end else if (beat) begin
      acc <= acc_next;
      cnt <= cnt_base + CW'(1);
      if (closing) begin
        m_data  <= acc_next;
        m_beats <= cnt_base + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_mod_acc_2011.sv
// Bench for mod_acc_2011: frame-level model (integer sum mod MOD) checked every cycle,
// plus literal expectations per directed scenario. Honors MOD_ACC_RANGE_CHECK_EN.
module tb_mod_acc_2011;
  localparam int MOD = 2011, W = 11, NCHUNK = 84, CW = 7;

  logic          clk = 1'b0;
  logic          rst_n, s_valid, s_last, m_ready;
  logic [W-1:0]  s_data;
  logic          s_ready, m_valid, m_err;
  logic [W-1:0]  m_data;
  logic [CW-1:0] m_beats;

  int n_chk = 0, n_err = 0;

  mod_acc_2011 #(.MOD(MOD), .W(W), .NCHUNK(NCHUNK), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_beats(m_beats), .m_err(m_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame model: plain integer sum, residue taken only when the frame closes.
  int tot, nb, pending, exp_data, exp_beats, exp_err, err_acc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tot = 0; nb = 0; pending = 0; err_acc = 0;
      exp_data = 0; exp_beats = 0; exp_err = 0;
    end else if (pending != 0) begin
      if (m_ready) begin
        pending = 0; tot = 0; nb = 0; err_acc = 0;
      end
    end else if (s_valid) begin
      tot += int'(s_data);
      nb++;
`ifdef MOD_ACC_RANGE_CHECK_EN
      if (int'(s_data) >= MOD) err_acc = 1;
`endif
      if (s_last || nb == NCHUNK) begin
        pending = 1;
        exp_data = tot % MOD;
        exp_beats = nb;
        exp_err = err_acc;
      end
    end
  end

  // Every-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("s_ready", int'(s_ready), (pending == 0) ? 1 : 0);
      chk("m_valid", int'(m_valid), pending);
      if (pending != 0) begin
        chk("m_data", int'(m_data), exp_data);
        chk("m_beats", int'(m_beats), exp_beats);
        chk("m_err", int'(m_err), exp_err);
      end
    end
  end

  // Record every result taken by the downstream handshake.
  int res_d[$], res_b[$], res_e[$];
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      res_d.push_back(int'(m_data));
      res_b.push_back(int'(m_beats));
      res_e.push_back(int'(m_err));
    end
  end

  task automatic send(input int d, input bit last);
    bit rdy;
    int n;
    s_valid = 1'b1;
    s_data  = W'(d);
    s_last  = last;
    n = 0;
    do begin
      @(negedge clk);
      rdy = s_ready;
      @(posedge clk);
      n++;
    end while (!rdy && n < 200);
    if (!rdy) chk("send_timeout", 0, 1);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_res(input string name, input int idx, input int d, input int b, input int e);
    if (res_d.size() <= idx) begin
      chk({name, "_present"}, res_d.size(), idx + 1);
    end else begin
      chk({name, "_data"}, res_d[idx], d);
      chk({name, "_beats"}, res_b[idx], b);
      chk({name, "_err"}, res_e[idx], e);
    end
  endtask

  task automatic clear_res();
    res_d.delete(); res_b.delete(); res_e.delete();
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_s_ready"}, int'(s_ready), 1);
    chk({name, "_m_valid"}, int'(m_valid), 0);
    chk({name, "_m_data"}, int'(m_data), 0);
    chk({name, "_m_beats"}, int'(m_beats), 0);
    chk({name, "_m_err"}, int'(m_err), 0);
  endtask

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0; m_ready = 1'b1;
    #1 chk_reset_outputs("reset");
    idle(2);
    rst_n = 1'b1;
    idle(1);

    // Wrap to exactly zero.
    clear_res();
    send(2010, 0); send(1, 1);
    @(negedge clk);
    chk("two_beat_valid_next_cycle", int'(m_valid), 1);
    idle(2);
    expect_res("two_beat", 0, 0, 2, 0);

    // Sum exceeding twice the modulus over the frame.
    clear_res();
    send(2010, 0); send(2010, 0); send(5, 1);
    idle(3);
    expect_res("three_beat", 0, 3, 3, 0);

    // 90 beats with no last: forced close at 84, then 6-beat frame.
    clear_res();
    for (int i = 1; i <= 90; i++) send(2010, i == 90);
    idle(3);
    expect_res("forced_close", 0, 1927, 84, 0);
    expect_res("after_forced", 1, 2005, 6, 0);

    // Output back-pressure for 10 cycles with a pending input beat.
    clear_res();
    m_ready = 1'b0;
    send(5, 0); send(6, 1);
    fork
      send(9, 1);
      begin
        repeat (10) begin
          @(negedge clk);
          chk("stall_m_data", int'(m_data), 11);
          chk("stall_s_ready", int'(s_ready), 0);
        end
        @(posedge clk);
        #1 m_ready = 1'b1;
      end
    join
    idle(3);
    expect_res("stall_first", 0, 11, 2, 0);
    expect_res("stall_second", 1, 9, 1, 0);

    // Reset mid-frame discards the partial sum.
    clear_res();
    send(1000, 0); send(1000, 0); send(1000, 0);
    rst_n = 1'b0;
    #1 chk_reset_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    send(7, 1);
    idle(3);
    chk("midreset_results", res_d.size(), 1);
    expect_res("after_reset", 0, 7, 1, 0);

`ifdef MOD_ACC_RANGE_CHECK_EN
    clear_res();
    send(2047, 0); send(0, 1);
    idle(3);
    send(3, 1);
    idle(3);
    expect_res("range_bad", 0, 36, 2, 1);
    expect_res("range_clean", 1, 3, 1, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
